// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the constants used by the ALU self-test.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    localparam int unsigned ALU_OP_COUNT = 10;
    localparam word_t       BIST_POLY    = 32'h0040_0007;

    typedef enum logic [1:0] {
        BIST_IDLE,
        BIST_RUN,
        BIST_DONE
    } bist_state_t;

    // One shift of a left-shifting Galois LFSR with the given feedback taps.
    function automatic word_t galois_step(word_t q, word_t poly);
        return {q[30:0], 1'b0} ^ (q[31] ? poly : '0);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the ALU and whoever drives its operands.
interface alu_if;
    import cpu_types_pkg::*;

    word_t  PORTA;
    word_t  PORTB;
    aluop_t ALUOP;
    word_t  OUTPORT;
    logic   NEG;
    logic   OVF;
    logic   ZERO;

    modport tb  (output PORTA, PORTB, ALUOP, input  OUTPORT, NEG, OVF, ZERO);
    modport alu (input  PORTA, PORTB, ALUOP, output OUTPORT, NEG, OVF, ZERO);

endinterface

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and an XOR input, so the
// same block serves as an operand generator (din=0) or as a MISR.
module lfsr32
    import cpu_types_pkg::*;
#(
    parameter word_t SEED = 32'h0000_0001,
    parameter word_t POLY = BIST_POLY
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  advance_i,
    input  word_t din_i,
    output word_t q_o
);

    word_t q_q;
    word_t q_d;

    // Load wins over advance; otherwise shift and fold in din.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = SEED;
        end else if (advance_i) begin
            q_d = galois_step(q_q, POLY) ^ din_i;
        end
    end

    // State register, seeded on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps every opcode with LFSR operand pairs,
// compresses the ALU response into a MISR and compares it to GOLDEN.
module alu_bist
    import cpu_types_pkg::*;
#(
    parameter int unsigned NVEC   = 256,
    parameter word_t       SEED_A = 32'h0000_0001,
    parameter word_t       SEED_B = 32'h0000_0002,
    parameter word_t       GOLDEN = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    alu_if.tb     aluif,
    output logic  busy,
    output logic  done,
    output logic  pass,
    output word_t signature
);

    localparam int unsigned   CW         = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam logic [CW-1:0] VEC_LAST   = CW'(NVEC - 1);
    localparam logic [3:0]    OP_LAST    = 4'(ALU_OP_COUNT - 1);
    localparam word_t         SEED_A_EFF = (SEED_A == '0) ? 32'h0000_0001 : SEED_A;
    localparam word_t         SEED_B_EFF = (SEED_B == '0) ? 32'h0000_0001 : SEED_B;

    bist_state_t   state_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] vec_q;
    logic [3:0]    op_q;

    logic  accept;
    word_t opa;
    word_t opb;
    word_t sig;
    word_t misr_din;

    assign accept = start && (state_q != BIST_RUN);

    // Fold the ALU result and flags into the MISR input word.
    always_comb begin
        misr_din = aluif.OUTPORT ^ {29'b0, aluif.NEG, aluif.OVF, aluif.ZERO};
    end

    lfsr32 #(.SEED(SEED_A_EFF), .POLY(BIST_POLY)) u_lfsr_a (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (accept),
        .advance_i (busy_q),
        .din_i     ('0),
        .q_o       (opa)
    );

    lfsr32 #(.SEED(SEED_B_EFF), .POLY(BIST_POLY)) u_lfsr_b (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (accept),
        .advance_i (busy_q),
        .din_i     ('0),
        .q_o       (opb)
    );

    lfsr32 #(.SEED('0), .POLY(BIST_POLY)) u_misr (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (accept),
        .advance_i (busy_q),
        .din_i     (misr_din),
        .q_o       (sig)
    );

    // Sequencer: opcode outer loop, vector inner loop, registered busy/done.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= BIST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= '0;
            op_q    <= '0;
        end else begin
            case (state_q)
                BIST_IDLE, BIST_DONE: begin
                    if (start) begin
                        state_q <= BIST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        vec_q   <= '0;
                        op_q    <= '0;
                    end
                end
                BIST_RUN: begin
                    if (vec_q == VEC_LAST) begin
                        vec_q <= '0;
                        if (op_q == OP_LAST) begin
                            state_q <= BIST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            op_q    <= '0;
                        end else begin
                            op_q <= op_q + 4'd1;
                        end
                    end else begin
                        vec_q <= vec_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= BIST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operands are only presented while vectors are being applied.
    always_comb begin
        aluif.PORTA = busy_q ? opa : '0;
        aluif.PORTB = busy_q ? opb : '0;
        aluif.ALUOP = busy_q ? aluop_t'(op_q) : ALU_SLL;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig;
    assign pass      = done_q && (sig == GOLDEN);

endmodule
